seven_segment_reader: RTL and testbench
=======================================

# seven_segment_reader

Capture block that watches a multiplexed, active-low seven-segment display bus (segment lines plus one-hot anodes) and recovers the hexadecimal value being shown. It is the inverse of the segment decoder: segment patterns go in, nibbles come out. Each digit is captured only after its pattern has been stable for a set dwell time. Completed multi-digit frames are handed off over a valid/ready interface. It sits on the board-facing side as a self-check and readback monitor for any display driver in the design.

## Interface
- `DIGITS`, 4: number of multiplexed digits; output width is 4*DIGITS.
- `STABLE_CYCLES`, 4: consecutive identical samples required before a digit is captured; legal range 1..255.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `seg_i` input 7: segment lines, active-low (0 = lit); bit 0 = a … bit 6 = g.
- `an_i` input DIGITS: anode selects, active-low one-hot; bit i selects digit i (digit 0 = least significant nibble).
- `value_o` output 4*DIGITS: captured frame; digit i in bits [4i+3:4i].
- `digit_err_o` output DIGITS: bit i set means digit i held a pattern outside the 0–F set.
- `out_valid_o` output 1: frame available.
- `out_ready_i` input 1: consumer accepts the frame.
- `overrun_o` output 1: one-cycle pulse when a completed frame is dropped.

## Operation
- Sample pair S = {an_i, seg_i}, taken each cycle (after the synchronizer if enabled).
- Anode validity: S counts only when exactly one bit of an_i is low. Zero or multiple low bits reset the dwell counter and block capture.
- Dwell counter:
  - Saturating, width $clog2(STABLE_CYCLES+1).
  - Resets to 1 on any change of S.
  - Increments while S is unchanged.
- Capture occurs once per dwell, on the sample where the counter reaches STABLE_CYCLES. A `captured` flag suppresses repeat captures until S changes.
- Capture decode, for the selected digit:
  - A pattern matching one of the 16 package constants writes its nibble and clears that digit's error bit.
  - Any other pattern, including blank 7'h7F, writes nibble 0 and sets the error bit.
  - The digit's bit in `seen_mask` is set.
- Frame completion is the capture that makes `seen_mask` all-ones. On that cycle:
  - If the output register is free, or is being accepted on this same edge (out_valid_o && out_ready_i), the shadow nibbles and errors are copied to value_o/digit_err_o and out_valid_o is set.
  - Otherwise the frame is dropped and overrun_o pulses.
  - In both cases `seen_mask` clears.
- A repeated capture of an already-seen digit overwrites its shadow nibble.
- Handshake: out_valid_o clears on the edge where out_ready_i is high, unless a new frame loads on that same edge. value_o is stable while out_valid_o is high.
- Reset, including mid-dwell or mid-frame: all state clears immediately. value_o = 0, digit_err_o = 0, out_valid_o = 0, overrun_o = 0, seen_mask = 0, counter = 0, shadow = 0.

## Timing
- With synchronizer disabled: S stable from edge k means capture at edge k+STABLE_CYCLES−1, and out_valid_o rises at edge k+STABLE_CYCLES on frame completion.
- The synchronizer adds 2 cycles.
- overrun_o is asserted for exactly one cycle, on the cycle the frame is dropped.
- Throughput: one frame per DIGITS*STABLE_CYCLES cycles minimum.

## Configuration
- `SEVEN_SEGMENT_READER_SYNC_EN`:
  - Defined: seg_i and an_i pass through a 2-flop synchronizer (reset to all-ones, i.e. nothing lit and no anode), adding 2 cycles of latency.
  - Undefined: inputs are sampled directly, for use when they are already in the clk domain.

## Structure
- Package `seven_seg_pkg`:
  - SEG_HEX[16] active-low pattern constants (0x40, 0x79, 0x24, 0x30, 0x19, 0x12, 0x02, 0x78, 0x00, 0x10, 0x08, 0x03, 0x46, 0x21, 0x06, 0x0E).
  - SEG_BLANK = 7'h7F.
  - These constants are shared with the existing hex-to-segment decoder.
- Sub-module `seven_segment_pattern_decode`: combinational, 7-bit pattern in; {hit, nibble[3:0]} out.

## Test plan
- DIGITS=4, STABLE_CYCLES=4, sync off. Scan an_i 1110/1101/1011/0111 with patterns 4/3/2/1, 4 cycles each, out_ready_i=1 → value_o=16'h1234, digit_err_o=0, out_valid_o high 1 cycle after the last capture.
- Hold the digit 0 pattern for only 3 cycles, then change it → no capture; seen_mask bit 0 stays 0 and no frame is produced.
- Digit 2 shows 7'h7F, other digits A/B/C → value_o=16'hC0BA... with digit_err_o=4'b0100.
- an_i=4'b1100 for 10 cycles → no capture. Then a valid scan → normal frame.
- out_ready_i=0 with two full scans → first frame held unchanged; overrun_o pulses once at the second completion. Raise out_ready_i → out_valid_o drops next edge.
- Assert rst_n low mid-scan after 2 digits captured → all outputs 0. A full scan after release is needed before out_valid_o rises.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared seven-segment constants: active-low patterns for hex digits 0-F and blank.
// Used by both the hex-to-segment decoder and the segment readback monitor.
package seven_seg_pkg;

    localparam int NUM_PATTERNS = 16;

    // Index i holds the lit-low pattern for nibble i; bit 0 = segment a, bit 6 = g.
    localparam logic [6:0] SEG_HEX [NUM_PATTERNS] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seven_segment_pattern_decode.sv
// Combinational inverse of the hex-to-segment table: a 7-bit active-low pattern
// maps to its nibble with hit_o set, or to nibble 0 with hit_o clear.
module seven_segment_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic       hit_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        hit_o    = 1'b0;
        nibble_o = 4'h0;
        for (int i = 0; i < NUM_PATTERNS; i++) begin
            if (pattern_i == SEG_HEX[i]) begin
                hit_o    = 1'b1;
                nibble_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seven_segment_reader.sv
// Recovers hex digits from a multiplexed active-low seven-segment bus and hands
// off completed frames over valid/ready. Define SEVEN_SEGMENT_READER_SYNC_EN to
// add a 2-flop input synchronizer.
module seven_segment_reader
    import seven_seg_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_i,
    input  logic [DIGITS-1:0]     an_i,
    output logic [4*DIGITS-1:0]   value_o,
    output logic [DIGITS-1:0]     digit_err_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  overrun_o
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int SW = DIGITS + 7;
    localparam logic [CW-1:0]     CNT_ONE    = CW'(1);
    localparam logic [CW-1:0]     CNT_TARGET = CW'(STABLE_CYCLES);
    localparam logic [DIGITS-1:0] SEL_ONE    = DIGITS'(1);

    logic [SW-1:0] samp;

`ifdef SEVEN_SEGMENT_READER_SYNC_EN
    logic [SW-1:0] sync1_q;
    logic [SW-1:0] sync2_q;

    // Reset to all-ones: no anode selected, nothing lit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {an_i, seg_i};
            sync2_q <= sync1_q;
        end
    end
    assign samp = sync2_q;
`else
    assign samp = {an_i, seg_i};
`endif

    logic [DIGITS-1:0] sel;
    logic [6:0]        seg_s;
    logic              sel_valid;

    assign sel       = ~samp[SW-1:7];
    assign seg_s     = samp[6:0];
    assign sel_valid = (sel != '0) && ((sel & (sel - SEL_ONE)) == '0);

    logic       dec_hit;
    logic [3:0] dec_nibble;

    seven_segment_pattern_decode u_decode (
        .pattern_i (seg_s),
        .hit_o     (dec_hit),
        .nibble_o  (dec_nibble)
    );

    logic [SW-1:0]       s_q;
    logic [CW-1:0]       cnt_q,      cnt_d;
    logic                captured_q, captured_d;
    logic [DIGITS-1:0]   seen_q,     seen_d;
    logic                complete_q, complete_d;
    logic [4*DIGITS-1:0] value_q,    value_d;
    logic [DIGITS-1:0]   err_q,      err_d;
    logic                out_valid_q, out_valid_d;
    logic                overrun_q,  overrun_d;

    logic                changed;
    logic                capture;
    logic [DIGITS-1:0]   seen_mark;
    logic [4*DIGITS-1:0] shadow_nib;
    logic [DIGITS-1:0]   shadow_err;

    always_comb begin
        changed    = (samp != s_q);
        cnt_d      = cnt_q;
        if (!sel_valid) begin
            cnt_d = '0;
        end else if (changed) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q != CNT_TARGET) begin
            cnt_d = cnt_q + 1'b1;
        end

        // A change of S re-arms capture even if the previous pattern was captured.
        capture    = sel_valid && (changed || !captured_q) && (cnt_d == CNT_TARGET);
        captured_d = capture || (captured_q && sel_valid && !changed);

        seen_mark  = seen_q | (capture ? sel : '0);
        complete_d = capture && (seen_mark == '1);
        seen_d     = complete_d ? '0 : seen_mark;
    end

    // Frame completion is acted on one cycle after the completing capture.
    always_comb begin
        value_d     = value_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        overrun_d   = 1'b0;
        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
        if (complete_q) begin
            if (!out_valid_q || out_ready_i) begin
                value_d     = shadow_nib;
                err_d       = shadow_err;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= '0;
            cnt_q       <= '0;
            captured_q  <= 1'b0;
            seen_q      <= '0;
            complete_q  <= 1'b0;
            value_q     <= '0;
            err_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            s_q         <= samp;
            cnt_q       <= cnt_d;
            captured_q  <= captured_d;
            seen_q      <= seen_d;
            complete_q  <= complete_d;
            value_q     <= value_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_shadow
            logic [3:0] nib_q;
            logic       err_bit_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    nib_q     <= 4'h0;
                    err_bit_q <= 1'b0;
                end else if (capture && sel[gi]) begin
                    nib_q     <= dec_nibble;
                    err_bit_q <= !dec_hit;
                end
            end

            assign shadow_nib[4*gi +: 4] = nib_q;
            assign shadow_err[gi]        = err_bit_q;
        end
    endgenerate

    assign value_o     = value_q;
    assign digit_err_o = err_q;
    assign out_valid_o = out_valid_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed self-checking bench for seven_segment_reader (DIGITS=4,
// STABLE_CYCLES=4, synchronizer off).
module tb_seven_segment_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_i;
    logic [3:0]  an_i;
    logic [15:0] value_o;
    logic [3:0]  digit_err_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        overrun_o;

    int compared   = 0;
    int mismatched = 0;

    // Active-low segment codes for 0..F, written out independently of the RTL.
    logic [6:0] seg_code [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seven_segment_reader #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_i       (seg_i),
        .an_i        (an_i),
        .value_o     (value_o),
        .digit_err_o (digit_err_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .overrun_o   (overrun_o)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_i  = an;
        seg_i = seg;
        step(n);
    endtask

    task automatic idle();
        an_i  = 4'hF;
        seg_i = 7'h7F;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-18s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic scan(input logic [3:0] d0, input logic [3:0] d1,
                        input logic [3:0] d2, input logic [3:0] d3);
        show(4'b1110, seg_code[d0], 4);
        show(4'b1101, seg_code[d1], 4);
        show(4'b1011, seg_code[d2], 4);
        show(4'b0111, seg_code[d3], 4);
    endtask

    initial begin
        rst_n       = 1'b0;
        out_ready_i = 1'b1;
        idle();
        step(3);
        check("rst_value",   32'(value_o),     32'h0);
        check("rst_err",     32'(digit_err_o), 32'h0);
        check("rst_valid",   32'(out_valid_o), 32'h0);
        check("rst_overrun", 32'(overrun_o),   32'h0);
        rst_n = 1'b1;
        step(2);

        // Basic scan: digits 0..3 show 4,3,2,1
        scan(4'h4, 4'h3, 4'h2, 4'h1);
        check("t1_valid_at_cap", 32'(out_valid_o), 32'h0);
        idle();
        step(1);
        check("t1_valid",  32'(out_valid_o), 32'h1);
        check("t1_value",  32'(value_o),     32'h1234);
        check("t1_err",    32'(digit_err_o), 32'h0);
        step(1);
        check("t1_valid_drop", 32'(out_valid_o), 32'h0);

        // Short dwell on digit 0 must not capture
        show(4'b1110, seg_code[5], 3);
        show(4'b1101, seg_code[8], 4);
        show(4'b1011, seg_code[9], 4);
        show(4'b0111, seg_code[10], 4);
        idle();
        step(3);
        check("t2_no_frame", 32'(out_valid_o), 32'h0);
        show(4'b1110, seg_code[7], 4);
        idle();
        step(1);
        check("t2_valid", 32'(out_valid_o), 32'h1);
        check("t2_value", 32'(value_o),     32'hA987);
        step(1);

        // Blank digit 2 gives nibble 0 and an error flag
        show(4'b1110, seg_code[10], 4);
        show(4'b1101, seg_code[11], 4);
        show(4'b1011, 7'h7F, 4);
        show(4'b0111, seg_code[12], 4);
        idle();
        step(1);
        check("t3_valid", 32'(out_valid_o), 32'h1);
        check("t3_value", 32'(value_o),     32'hC0BA);
        check("t3_err",   32'(digit_err_o), 32'h4);
        step(1);

        // Two anodes low is ignored; err bit 2 clears on a good capture
        show(4'b1101, seg_code[14], 4);
        show(4'b1011, seg_code[15], 4);
        show(4'b0111, seg_code[0], 4);
        show(4'b1100, seg_code[1], 10);
        idle();
        step(2);
        check("t4_no_frame", 32'(out_valid_o), 32'h0);
        show(4'b1110, seg_code[13], 4);
        idle();
        step(1);
        check("t4_valid", 32'(out_valid_o), 32'h1);
        check("t4_value", 32'(value_o),     32'h0FED);
        check("t4_err",   32'(digit_err_o), 32'h0);
        step(1);

        // Backpressure: second frame is dropped
        out_ready_i = 1'b0;
        scan(4'h1, 4'h2, 4'h3, 4'h4);
        idle();
        step(1);
        check("t5_valid1", 32'(out_valid_o), 32'h1);
        check("t5_value1", 32'(value_o),     32'h4321);
        scan(4'h5, 4'h6, 4'h7, 4'h8);
        check("t5_ovr_before", 32'(overrun_o), 32'h0);
        idle();
        step(1);
        check("t5_ovr_pulse",  32'(overrun_o),   32'h1);
        check("t5_value_held", 32'(value_o),     32'h4321);
        check("t5_valid_held", 32'(out_valid_o), 32'h1);
        step(1);
        check("t5_ovr_end", 32'(overrun_o), 32'h0);
        out_ready_i = 1'b1;
        step(1);
        check("t5_valid_drop", 32'(out_valid_o), 32'h0);

        // Asynchronous reset mid-scan
        out_ready_i = 1'b0;
        scan(4'h9, 4'hA, 4'hB, 4'hC);
        idle();
        step(1);
        check("t6_valid_pre", 32'(out_valid_o), 32'h1);
        check("t6_value_pre", 32'(value_o),     32'hCBA9);
        show(4'b1110, seg_code[3], 4);
        show(4'b1101, seg_code[5], 4);
        rst_n = 1'b0;
        #2;
        check("t6_rst_value",   32'(value_o),     32'h0);
        check("t6_rst_err",     32'(digit_err_o), 32'h0);
        check("t6_rst_valid",   32'(out_valid_o), 32'h0);
        check("t6_rst_overrun", 32'(overrun_o),   32'h0);
        idle();
        step(2);
        rst_n       = 1'b1;
        out_ready_i = 1'b1;
        show(4'b1011, seg_code[7], 4);
        show(4'b0111, seg_code[6], 4);
        idle();
        step(2);
        check("t6_partial", 32'(out_valid_o), 32'h0);
        show(4'b1110, seg_code[3], 4);
        show(4'b1101, seg_code[5], 4);
        idle();
        step(1);
        check("t6_valid", 32'(out_valid_o), 32'h1);
        check("t6_value", 32'(value_o),     32'h6753);
        step(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
